// File: rtl/anton_neopixel_stream_sequencer.sv
// Frame-level TRANSMIT/RESET sequencer for the NeoPixel stream datapath.
// Define ANTON_NEOPIXEL_FRAME_COUNTER_EN to add a 16-bit frame_count output.
`ifndef CLOG2
`define CLOG2(x) $clog2(x)
`endif
`ifndef BUFFER_END_DEFAULT
`define BUFFER_END_DEFAULT 255
`endif
`ifndef ENUM_STATE_TRANSMIT
`define ENUM_STATE_TRANSMIT 1'b0
`endif
`ifndef ENUM_STATE_RESET
`define ENUM_STATE_RESET 1'b1
`endif

module anton_neopixel_stream_sequencer #(
  parameter int BUFFER_END   = `BUFFER_END_DEFAULT,
  parameter int BUFFER_BITS  = `CLOG2(BUFFER_END + 1),
  parameter int RESET_CYCLES = 400
) (
  input  logic                   clk7mhz,
  input  logic                   rst,
  input  logic                   reg_ctrl_init,
  input  logic                   reg_ctrl_run,
  input  logic                   reg_ctrl_loop,
  input  logic                   reg_ctrl_32bit,
  input  logic                   stream_bit_of,
  input  logic                   stream_pixel_of,
  output logic                   state,
  output logic [BUFFER_BITS-1:0] pixel_index,
  output logic                   busy,
  output logic                   frame_done,
`ifdef ANTON_NEOPIXEL_FRAME_COUNTER_EN
  output logic [15:0]            frame_count,
`endif
  output logic                   run_clear
);

  localparam int RESET_BITS = `CLOG2(RESET_CYCLES);
  localparam logic [RESET_BITS-1:0]  LAST_COUNT = RESET_BITS'(RESET_CYCLES - 1);
  localparam logic [BUFFER_BITS-1:0] STEP_8     = BUFFER_BITS'(1);
  localparam logic [BUFFER_BITS-1:0] STEP_32    = BUFFER_BITS'(4);
  localparam logic [BUFFER_BITS-1:0] WORD_MASK  = BUFFER_BITS'(3);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRANSMIT,
    ST_RESET
  } fsm_t;

  fsm_t                   fsm;
  logic [RESET_BITS-1:0]  reset_count;
  logic [BUFFER_BITS-1:0] next_index;

  // 32-bit buffers are word aligned, so a step also snaps the low bits to zero.
  always_comb begin
    next_index = pixel_index + (reg_ctrl_32bit ? STEP_32 : STEP_8);
    if (reg_ctrl_32bit) next_index = next_index & ~WORD_MASK;
  end

  always_ff @(posedge clk7mhz or posedge rst) begin
    if (rst) begin
      fsm         <= ST_IDLE;
      pixel_index <= '0;
      reset_count <= '0;
      frame_done  <= 1'b0;
      run_clear   <= 1'b0;
      state       <= `ENUM_STATE_RESET;
      busy        <= 1'b0;
    end else if (reg_ctrl_init) begin
      fsm         <= ST_IDLE;
      pixel_index <= '0;
      reset_count <= '0;
      frame_done  <= 1'b0;
      run_clear   <= 1'b0;
      state       <= `ENUM_STATE_RESET;
      busy        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      run_clear  <= 1'b0;
      if (reg_ctrl_run) begin
        case (fsm)
          // run stays high one edge after run_clear; holding here stops a stray frame.
          ST_IDLE: begin
            if (!run_clear) begin
              fsm         <= ST_TRANSMIT;
              pixel_index <= '0;
              state       <= `ENUM_STATE_TRANSMIT;
              busy        <= 1'b1;
            end
          end
          ST_TRANSMIT: begin
            if (stream_bit_of) begin
              if (stream_pixel_of) begin
                fsm         <= ST_RESET;
                pixel_index <= '0;
                reset_count <= '0;
                state       <= `ENUM_STATE_RESET;
              end else begin
                pixel_index <= next_index;
              end
            end
          end
          ST_RESET: begin
            if (reset_count == LAST_COUNT) begin
              reset_count <= '0;
              frame_done  <= 1'b1;
              if (reg_ctrl_loop) begin
                fsm         <= ST_TRANSMIT;
                pixel_index <= '0;
                state       <= `ENUM_STATE_TRANSMIT;
              end else begin
                fsm       <= ST_IDLE;
                busy      <= 1'b0;
                run_clear <= 1'b1;
              end
            end else begin
              reset_count <= reset_count + 1'b1;
            end
          end
          default: begin
            fsm         <= ST_IDLE;
            pixel_index <= '0;
            reset_count <= '0;
            state       <= `ENUM_STATE_RESET;
            busy        <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef ANTON_NEOPIXEL_FRAME_COUNTER_EN
  logic gap_done;
  assign gap_done = reg_ctrl_run && (fsm == ST_RESET) && (reset_count == LAST_COUNT);

  always_ff @(posedge clk7mhz or posedge rst) begin
    if (rst)                frame_count <= '0;
    else if (reg_ctrl_init) frame_count <= '0;
    else if (gap_done)      frame_count <= frame_count + 16'd1;
  end
`endif

endmodule

// File: doc/anton_neopixel_stream_sequencer.md
Name: anton_neopixel_stream_sequencer

Overview:
- Frame-level sequencer for the NeoPixel stream datapath.
- Owns the 1-bit `state` (TRANSMIT/RESET) and `pixel_index` that the stream controller consumes.
- Consumes the stream controller's `stream_bit_of` / `stream_pixel_of` flags.
- Times the WS2812 latch/reset gap, then either loops to the next frame or stops and asks the register block to clear `reg_ctrl_run`.

Parameters:
- BUFFER_END, `BUFFER_END_DEFAULT, last valid buffer index; BUFFER_BITS = `CLOG2(BUFFER_END+1).
- RESET_CYCLES, 400, clk7mhz cycles spent in RESET (400 = 57.1 us, above the WS2812 50 us minimum); must be >= 2.
- RESET_BITS (localparam), `CLOG2(RESET_CYCLES), width of the reset-gap counter.

Ports:
- clk7mhz  in  1  7 MHz stream clock; the only clock.
- rst  in  1  asynchronous, active-high reset.
- reg_ctrl_init  in  1  synchronous re-initialise; overrides everything except rst.
- reg_ctrl_run  in  1  streaming enable; low freezes all sequencing.
- reg_ctrl_loop  in  1  1 = restart after the reset gap; 0 = single frame.
- reg_ctrl_32bit  in  1  32-bit buffer mode; pixel_index steps by 4.
- stream_bit_of  in  1  last sub-bit of the last bit of the current pixel.
- stream_pixel_of  in  1  current pixel is the last reachable pixel.
- state  out  1  `ENUM_STATE_TRANSMIT or `ENUM_STATE_RESET.
- pixel_index  out  BUFFER_BITS  current pixel/buffer index.
- busy  out  1  high in TRANSMIT or RESET.
- frame_done  out  1  one-cycle pulse when a reset gap completes.
- run_clear  out  1  one-cycle pulse requesting `reg_ctrl_run` <= 0.

Behaviour:
- FSM states:
  - IDLE: drives `state`=RESET, busy=0.
  - TRANSMIT: drives `state`=TRANSMIT, busy=1.
  - RESET: drives `state`=RESET, busy=1.
- On rst (async):
  - FSM=IDLE, pixel_index=0, reset counter=0.
  - frame_done=0, run_clear=0; `state`=RESET.
- All outputs are registered; frame_done and run_clear are never high two consecutive cycles.
- reg_ctrl_init=1 (sync, highest priority after rst):
  - Next edge: FSM=IDLE, pixel_index=0, counter=0.
  - No frame_done or run_clear pulse is issued.
- reg_ctrl_run=0: all state, counters and pixel_index hold (pause); resume in place when run returns high.
- IDLE -> TRANSMIT when reg_ctrl_run=1 and run_clear=0 (the current registered value). pixel_index=0 on entry.
- TRANSMIT, on a stream_bit_of cycle:
  - If stream_pixel_of=1: go to RESET, pixel_index <= 0, counter <= 0.
  - Otherwise stay in TRANSMIT; pixel_index <= pixel_index + (reg_ctrl_32bit ? 4 : 1).
  - In 32-bit mode pixel_index[1:0] is forced to 0 on each step.
  - Additions wrap modulo 2^BUFFER_BITS.
- RESET:
  - Counter increments each run cycle.
  - When counter == RESET_CYCLES-1: frame_done=1 the next cycle, and counter <= 0.
  - If reg_ctrl_loop=1: go to TRANSMIT.
  - Otherwise: go to IDLE with run_clear=1 on the same edge.
- Register timing: the register block drops run one edge after run_clear. Gating the IDLE exit on run_clear guarantees no TRANSMIT cycle leaks through.
- reg_ctrl_loop is sampled only at the end of the reset gap. Changing it mid-frame has no effect until then.
- reg_ctrl_32bit changing mid-frame takes effect on the next pixel step.
- stream_bit_of outside TRANSMIT is ignored.

Optional Feature:
- Macro: ANTON_NEOPIXEL_FRAME_COUNTER_EN.
- Defined:
  - Adds output `frame_count` (16 bits), reset to 0 by rst or reg_ctrl_init.
  - Increments on every frame_done; wraps 0xFFFF -> 0.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: assert rst mid-TRANSMIT at pixel_index=5 -> same cycle state=RESET, pixel_index=0, busy=0, no pulses.
- Single frame (BUFFER_END=3, 8-bit mode, loop=0, run=1):
  - Feed stream_bit_of every 192 cycles; stream_pixel_of high at index 3 -> pixel_index 0,1,2,3 then RESET.
  - After exactly 400 cycles: frame_done and run_clear pulse together, FSM IDLE.
  - Run held high by the bench for 1 extra cycle -> no return to TRANSMIT.
- Loop (loop=1): two frames back-to-back -> TRANSMIT re-entered the cycle after frame_done, pixel_index restarts at 0, run_clear never pulses.
- 32-bit mode (BUFFER_END=15) -> pixel_index sequence 0,4,8,12 then RESET when stream_pixel_of is asserted.
- Pause and init:
  - Run=0 for 50 cycles at RESET counter=100 -> counter holds 100, then completes after the remaining 300 run cycles.
  - reg_ctrl_init mid-TRANSMIT -> IDLE, pixel_index=0, no pulses.
- With ANTON_NEOPIXEL_FRAME_COUNTER_EN: 3 looped frames -> frame_count=3; reg_ctrl_init -> 0.
